// File: rtl/mem_sp_arbiter_pkg.sv
// rtl/mem_sp_arbiter_pkg.sv - shared widths and types for the single-port RAM arbiter
package mem_sp_arbiter_pkg;
  localparam int WIDTH_DATA  = 32;
  localparam int CNT_CHANNLS = 4;

  typedef enum logic {ARB, LOCK} arb_st_t;

  typedef struct packed {
    logic       v;
    logic [1:0] id;
  } rd_tag_t;
endpackage

// File: rtl/mem_sp_arbiter_if.sv
// rtl/mem_sp_arbiter_if.sv - requester-side request/response bundle for mem_sp_arbiter
interface mem_sp_arbiter_if #(
  parameter int T_MSZ = 12,
  parameter int N_REQ = 2
) ();
  import mem_sp_arbiter_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_lock;
  logic [N_REQ-1:0]             req_we;
  logic [N_REQ*T_MSZ-1:0]       req_addr;
  logic [N_REQ*WIDTH_DATA-1:0]  req_wdata;
  logic [N_REQ*CNT_CHANNLS-1:0] req_be;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             rsp_valid;
  logic [WIDTH_DATA-1:0]        rsp_data;

  modport master (
    output req_valid, req_lock, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_lock, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_sp_arbiter_rd_pipe.sv
// rtl/mem_sp_arbiter_rd_pipe.sv - RD_LAT-deep read tag delay line, aligns tag with RAM Q
module mem_sp_arbiter_rd_pipe
  import mem_sp_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);
  rd_tag_t pipe_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];
endmodule

// File: rtl/mem_sp_arbiter.sv
// rtl/mem_sp_arbiter.sv - round-robin arbiter sharing one single-port byte-enable RAM
// Optional MEM_ARB_STATS_EN adds per-requester grant and conflict counters.
module mem_sp_arbiter
  import mem_sp_arbiter_pkg::*;
#(
  parameter int T_MSZ  = 12,
  parameter int N_REQ  = 2,
  parameter int RD_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  mem_sp_arbiter_if.slave        bus,
  output logic [T_MSZ-1:0]       mem_a,
  output logic [WIDTH_DATA-1:0]  mem_d,
  output logic                   mem_ce,
  output logic [CNT_CHANNLS-1:0] mem_we,
  input  logic [WIDTH_DATA-1:0]  mem_q
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    stat_grants,
  output logic [15:0]            stat_conflict
`endif
);
  arb_st_t                st_q;
  logic [1:0]             ptr_q, owner_q, ptr_d, sel;
  logic                   found, acc;
  logic [N_REQ-1:0]       ready;
  logic                   a_we, a_lock;
  logic [T_MSZ-1:0]       a_addr;
  logic [WIDTH_DATA-1:0]  a_wdata;
  logic [CNT_CHANNLS-1:0] a_be;
  logic [T_MSZ-1:0]       mem_a_q;
  logic [WIDTH_DATA-1:0]  mem_d_q;
  logic                   mem_ce_q;
  logic [CNT_CHANNLS-1:0] mem_we_q;
  rd_tag_t                cmd_tag_q, rsp_tag;

  // Rotating priority: first pass covers ptr..N_REQ-1, second pass wraps to 0.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    ready = '0;
    if (st_q == LOCK) begin
      sel = owner_q;
      for (int k = 0; k < N_REQ; k++)
        if (2'(k) == owner_q) ready[k] = bus.req_valid[k];
    end else begin
      for (int k = 0; k < N_REQ; k++)
        if (!found && bus.req_valid[k] && (2'(k) >= ptr_q)) begin
          found = 1'b1;
          sel   = 2'(k);
        end
      for (int k = 0; k < N_REQ; k++)
        if (!found && bus.req_valid[k]) begin
          found = 1'b1;
          sel   = 2'(k);
        end
      for (int k = 0; k < N_REQ; k++)
        if (found && (2'(k) == sel)) ready[k] = 1'b1;
    end
    ptr_d = (sel == 2'(N_REQ-1)) ? 2'd0 : sel + 2'd1;
  end

  always_comb begin
    a_we    = 1'b0;
    a_lock  = 1'b0;
    a_addr  = '0;
    a_wdata = '0;
    a_be    = '0;
    for (int k = 0; k < N_REQ; k++)
      if (ready[k]) begin
        a_we    = bus.req_we[k];
        a_lock  = bus.req_lock[k];
        a_addr  = bus.req_addr[k*T_MSZ +: T_MSZ];
        a_wdata = bus.req_wdata[k*WIDTH_DATA +: WIDTH_DATA];
        a_be    = bus.req_be[k*CNT_CHANNLS +: CNT_CHANNLS];
      end
    acc = |ready;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q      <= ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      mem_ce_q  <= 1'b0;
      mem_we_q  <= '0;
      cmd_tag_q <= '0;
    end else begin
      mem_ce_q  <= 1'b0;
      mem_we_q  <= '0;
      cmd_tag_q <= '0;
      if (acc) begin
        if (!a_we) begin
          mem_a_q      <= a_addr;
          mem_ce_q     <= 1'b1;
          cmd_tag_q.v  <= 1'b1;
          cmd_tag_q.id <= sel;
        end else if (|a_be) begin
          mem_a_q  <= a_addr;
          mem_d_q  <= a_wdata;
          mem_ce_q <= 1'b1;
          mem_we_q <= a_be;
        end
        if (st_q == ARB) begin
          ptr_q <= ptr_d;
          if (a_lock) begin
            st_q    <= LOCK;
            owner_q <= sel;
          end
        end else if (!a_lock) begin
          st_q <= ARB;
        end
      end
    end
  end

  mem_sp_arbiter_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk_i (CLK),
    .rst_i (RST),
    .tag_i (cmd_tag_q),
    .tag_o (rsp_tag)
  );

  assign mem_a         = mem_a_q;
  assign mem_d         = mem_d_q;
  assign mem_ce        = mem_ce_q;
  assign mem_we        = mem_we_q;
  assign bus.req_ready = ready;

  always_comb begin
    bus.rsp_valid = '0;
    for (int k = 0; k < N_REQ; k++)
      if (rsp_tag.v && (rsp_tag.id == 2'(k))) bus.rsp_valid[k] = 1'b1;
    bus.rsp_data = rsp_tag.v ? mem_q : '0;
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grants_q [N_REQ];
  logic [15:0] conflict_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_q <= '0;
      for (int k = 0; k < N_REQ; k++) grants_q[k] <= '0;
    end else begin
      if (($countones(bus.req_valid) > 1) && (conflict_q != 16'hFFFF))
        conflict_q <= conflict_q + 16'd1;
      for (int k = 0; k < N_REQ; k++)
        if (ready[k] && (grants_q[k] != 16'hFFFF)) grants_q[k] <= grants_q[k] + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grants_q[g];
  end
  assign stat_conflict = conflict_q;
`endif
endmodule

// File: tb/tb_mem_sp_arbiter.sv
// tb/tb_mem_sp_arbiter.sv - directed self-checking bench for mem_sp_arbiter with RAM model
module tb_mem_sp_arbiter;
  logic        clk;
  logic        rst;
  logic [11:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_ce;
  logic [3:0]  mem_we;
  logic [31:0] mem_q;
  logic [31:0] ram [0:4095];
  int          total;
  int          bad;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [15:0] stat_conflict;
`endif

  mem_sp_arbiter_if #(.T_MSZ(12), .N_REQ(2)) bus ();

  mem_sp_arbiter #(.T_MSZ(12), .N_REQ(2), .RD_LAT(1)) dut (
    .CLK    (clk),
    .RST    (rst),
    .bus    (bus),
    .mem_a  (mem_a),
    .mem_d  (mem_d),
    .mem_ce (mem_ce),
    .mem_we (mem_we),
    .mem_q  (mem_q)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_conflict (stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency; reset reloads the preloaded words.
  always @(posedge clk) begin
    if (rst) begin
      ram[12'h010] <= 32'hDEADBEEF;
      ram[12'h005] <= 32'hAABBCCDD;
      ram[12'h007] <= 32'h01020304;
    end else if (mem_ce) begin
      if (mem_we == 4'b0000) mem_q <= ram[mem_a];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) ram[mem_a][b*8 +: 8] <= mem_d[b*8 +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic lk, input logic we,
                         input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_valid[k]         = v;
    bus.req_lock[k]          = lk;
    bus.req_we[k]            = we;
    bus.req_addr[k*12 +: 12] = a;
    bus.req_wdata[k*32 +: 32] = d;
    bus.req_be[k*4 +: 4]     = be;
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", bus.req_ready); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
    total++; if (mem_ce !== 1'b0 || mem_we !== 4'h0) begin bad++; $display("FAIL reset_mem_ctl got=%b/%b want=0/0", mem_ce, mem_we); end
    total++; if (mem_a !== 12'h0 || mem_d !== 32'h0) begin bad++; $display("FAIL reset_mem_ad got=%h/%h want=0/0", mem_a, mem_d); end
  endtask

  task automatic test_read();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rd_ready got=%b want=01", bus.req_ready); end
    tick();
    idle();
    total++; if (mem_ce !== 1'b1 || mem_we !== 4'h0 || mem_a !== 12'h010) begin bad++; $display("FAIL rd_cmd got=ce%b we%b a%h want=ce1 we0 a010", mem_ce, mem_we, mem_a); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_early_rsp got=%b want=00", bus.rsp_valid); end
    tick();
    total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rsp got=%b/%h want=01/deadbeef", bus.rsp_valid, bus.rsp_data); end
    total++; if (mem_ce !== 1'b0) begin bad++; $display("FAIL rd_idle_ce got=%b want=0", mem_ce); end
    tick();
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_rsp_once got=%b want=00", bus.rsp_valid); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (bus.req_ready !== exp_g) begin bad++; $display("FAIL alt_grant%0d got=%b want=%b", i, bus.req_ready, exp_g); end
      if (i >= 2) begin
        total++; if (bus.rsp_valid !== exp_g || bus.rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alt_rsp%0d got=%b/%h want=%b/deadbeef", i, bus.rsp_valid, bus.rsp_data, exp_g); end
      end
      tick();
    end
`ifdef MEM_ARB_STATS_EN
    total++; if (stat_grants !== {16'd4, 16'd4}) begin bad++; $display("FAIL alt_stat_grants got=%h want=00040004", stat_grants); end
    total++; if (stat_conflict !== 16'd8) begin bad++; $display("FAIL alt_stat_conflict got=%0d want=8", stat_conflict); end
`endif
    idle();
    tick();
    tick();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b0, 1'b1, 12'h005, 32'h11223344, 4'b0011);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b want=01", bus.req_ready); end
    tick();
    idle();
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h005, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL wr_rd_ready got=%b want=10", bus.req_ready); end
    total++; if (mem_ce !== 1'b1 || mem_we !== 4'b0011 || mem_a !== 12'h005 || mem_d !== 32'h11223344) begin bad++; $display("FAIL wr_cmd got=ce%b we%b a%h d%h want=ce1 we3 a005 d11223344", mem_ce, mem_we, mem_a, mem_d); end
    tick();
    idle();
    total++; if (mem_ce !== 1'b1 || mem_we !== 4'h0) begin bad++; $display("FAIL wr_rd_cmd got=ce%b we%b want=ce1 we0", mem_ce, mem_we); end
    tick();
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'hAABB3344) begin bad++; $display("FAIL wr_rd_rsp got=%b/%h want=10/aabb3344", bus.rsp_valid, bus.rsp_data); end
    tick();
  endtask

  task automatic test_lock();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL lock_c0 got=%b want=01", bus.req_ready); end
    tick();
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL lock_beat1 got=%b want=10", bus.req_ready); end
    tick();
    set_req(1, 1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL lock_hold got=%b want=00", bus.req_ready); end
    tick();
    set_req(1, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL lock_beat2 got=%b want=10", bus.req_ready); end
    tick();
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL lock_beat3 got=%b want=10", bus.req_ready); end
    tick();
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL lock_release got=%b want=01", bus.req_ready); end
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_inflight();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    tick();
    idle();
    rst = 1'b1;
    total++; if (mem_ce !== 1'b1) begin bad++; $display("FAIL rst_cmd got=%b want=1", mem_ce); end
    tick();
    rst = 1'b0;
    total++; if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 32'h0 || mem_ce !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b/%h/ce%b want=00/0/ce0", bus.rsp_valid, bus.rsp_data, mem_ce); end
    tick();
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_late got=%b want=00", bus.rsp_valid); end
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rst_new_ready got=%b want=01", bus.req_ready); end
    tick();
    idle();
    tick();
    total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_new_rsp got=%b/%h want=01/deadbeef", bus.rsp_valid, bus.rsp_data); end
    tick();
  endtask

  task automatic test_be_zero();
    set_req(1, 1'b1, 1'b0, 1'b1, 12'h007, 32'hFFFFFFFF, 4'b0000);
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL be0_ready got=%b want=10", bus.req_ready); end
    tick();
    idle();
    total++; if (mem_ce !== 1'b0 || mem_we !== 4'h0) begin bad++; $display("FAIL be0_cmd got=ce%b we%b want=ce0 we0", mem_ce, mem_we); end
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h007, 32'h0, 4'h0);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL be0_rd_ready got=%b want=01", bus.req_ready); end
    tick();
    idle();
    tick();
    total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'h01020304) begin bad++; $display("FAIL be0_rd_rsp got=%b/%h want=01/01020304", bus.rsp_valid, bus.rsp_data); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_read();
    test_alternate();
    test_write_read();
    test_lock();
    test_reset_inflight();
    test_be_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
